// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state type and constants for mem_port_arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        KEY_HOLD,
        RESP
    } arb_state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam logic [31:0] KEY_ADDR_DEFAULT = 32'd16383;
    localparam int          PERF_W           = 16;

endpackage

// File: rtl/mem_arb_priority.sv
// rtl/mem_arb_priority.sv - fixed port-0 priority with port-1 starvation override
module mem_arb_priority
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic arb_en,
    output logic gnt0,
    output logic gnt1
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             p1_forced;

    assign p1_forced = (starve_cnt == CNT_W'(STARVE_MAX));
    assign gnt1      = arb_en && req1 && (!req0 || p1_forced);
    assign gnt0      = arb_en && req0 && !gnt1;

    // Counts consecutive port-0 wins while port 1 is waiting; saturates at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!req1 || gnt1) begin
            starve_cnt <= '0;
        end else if (gnt0 && !p1_forced) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port arbiter for the data memory with keyboard-read sequencing
// Optional grant/key-read counters when MEM_ARB_PERF_EN is defined.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] KEY_ADDR   = ADDR_W'(KEY_ADDR_DEFAULT),
    parameter int                STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0] p0_grants,
    output logic [PERF_W-1:0] p1_grants,
    output logic [PERF_W-1:0] key_reads
`endif
);

    arb_state_t        state;
    logic              arb_en;
    logic              gnt0;
    logic              gnt1;
    logic              any_gnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_key;
    logic              owner;
    logic              lat_we;
    logic              lat_key;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid0_q;
    logic              rvalid1_q;

    assign arb_en = (state == IDLE) || (state == RESP);

    mem_arb_priority #(
        .STARVE_MAX(STARVE_MAX)
    ) u_priority (
        .clk   (clk),
        .rst_n (rst_n),
        .req0  (p0_req),
        .req1  (p1_req),
        .arb_en(arb_en),
        .gnt0  (gnt0),
        .gnt1  (gnt1)
    );

    assign any_gnt   = gnt0 | gnt1;
    assign sel_we    = gnt1 ? p1_we    : p0_we;
    assign sel_addr  = gnt1 ? p1_addr  : p0_addr;
    assign sel_wdata = gnt1 ? p1_wdata : p0_wdata;
    assign sel_key   = !sel_we && (sel_addr == KEY_ADDR);

    assign p0_gnt    = gnt0;
    assign p1_gnt    = gnt1;
    assign p0_rvalid = rvalid0_q;
    assign p1_rvalid = rvalid1_q;
    assign p0_rdata  = rdata_q;
    assign p1_rdata  = rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= PORT0;
            lat_we    <= 1'b0;
            lat_key   <= 1'b0;
            rdata_q   <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wd    <= '0;
        end else begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            unique case (state)
                IDLE, RESP: begin
                    if (any_gnt) begin
                        state    <= ACCESS;
                        owner    <= gnt1 ? PORT1 : PORT0;
                        lat_we   <= sel_we;
                        lat_key  <= sel_key;
                        // Port 1 must never present the keyboard address, or it would consume the key.
                        mem_addr <= (gnt1 && sel_key) ? '0 : sel_addr;
                        mem_we   <= sel_we;
                        mem_wd   <= sel_wdata;
                    end else begin
                        state    <= IDLE;
                        mem_addr <= '0;
                        mem_we   <= 1'b0;
                        mem_wd   <= '0;
                    end
                end
                ACCESS: begin
                    mem_we <= 1'b0;
                    mem_wd <= '0;
                    if (lat_key && owner == PORT0) begin
                        state <= KEY_HOLD;
                    end else begin
                        state     <= RESP;
                        mem_addr  <= '0;
                        rdata_q   <= (lat_we || lat_key) ? '0 : mem_rd;
                        rvalid0_q <= (owner == PORT0);
                        rvalid1_q <= (owner == PORT1);
                    end
                end
                KEY_HOLD: begin
                    state     <= RESP;
                    mem_addr  <= '0;
                    rdata_q   <= mem_rd;
                    rvalid0_q <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    mem_addr <= '0;
                    mem_we   <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_grants <= '0;
            p1_grants <= '0;
            key_reads <= '0;
        end else begin
            if (gnt0) p0_grants <= p0_grants + 1'b1;
            if (gnt1) p1_grants <= p1_grants + 1'b1;
            if (state == KEY_HOLD) key_reads <= key_reads + 1'b1;
        end
    end
`endif

endmodule
